// File: rtl/uart_frame_assembler.sv
// Packs a UART byte stream into fixed-size frames, checks that the header byte
// equals the trailer byte and presents each good frame once under valid/ready.
`timescale 1ns/1ps

module uart_frame_assembler #(
    parameter int DBITS          = 8,
    parameter int FRAME_BYTES    = 18,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DBITS-1:0]                   rx_data,
    input  logic                               rx_valid,
    output logic [FRAME_BYTES*DBITS-1:0]       frame_data,
    output logic [DBITS-1:0]                   frame_cmd,
    output logic                               frame_valid,
    input  logic                               frame_ready,
    output logic                               err_mismatch,
    output logic                               err_timeout,
    output logic                               err_overrun,
    output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count
);

    localparam int FW = FRAME_BYTES * DBITS;
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BYTES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   frame_data_q, frame_data_d;
    logic [CW-1:0]   byte_count_q, byte_count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_mismatch_q, err_mismatch_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overrun_q, err_overrun_d;

    logic [FW-1:0]    shifted;
    logic [DBITS-1:0] header;

    assign shifted = {frame_data_q[FW-DBITS-1:0], rx_data};
    // Before the last byte is shifted in, the header sits one byte below the MSBs.
    assign header  = frame_data_q[FW-DBITS-1 -: DBITS];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        state_d        = state_q;
        frame_data_d   = frame_data_q;
        byte_count_d   = byte_count_q;
        timer_d        = timer_q;
        err_mismatch_d = 1'b0;
        err_timeout_d  = 1'b0;
        err_overrun_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    frame_data_d = shifted;
                    byte_count_d = CW'(1);
                    timer_d      = '0;
                    state_d      = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    frame_data_d = shifted;
                    timer_d      = '0;
                    if (byte_count_q == LAST_IDX) begin
                        if (header == rx_data) begin
                            byte_count_d = FULL_CNT;
                            state_d      = S_HOLD;
                        end else begin
                            err_mismatch_d = 1'b1;
                            byte_count_d   = '0;
                            state_d        = S_IDLE;
                        end
                    end else begin
                        byte_count_d = byte_count_q + CW'(1);
                    end
                end else if (timer_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    byte_count_d  = '0;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    if (rx_valid) begin
                        frame_data_d = shifted;
                        byte_count_d = CW'(1);
                        timer_d      = '0;
                        state_d      = S_COLLECT;
                    end else begin
                        byte_count_d = '0;
                        state_d      = S_IDLE;
                    end
                end else if (rx_valid) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            frame_data_q   <= '0;
            byte_count_q   <= '0;
            timer_q        <= '0;
            err_mismatch_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_data_q   <= frame_data_d;
            byte_count_q   <= byte_count_d;
            timer_q        <= timer_d;
            err_mismatch_q <= err_mismatch_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign frame_data   = frame_data_q;
    assign frame_cmd    = frame_data_q[DBITS-1:0];
    assign frame_valid  = (state_q == S_HOLD);
    assign byte_count   = byte_count_q;
    assign err_mismatch = err_mismatch_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: a table of whole frames plus
// hand-written sequences for timeout, back-pressure, simultaneous accept and reset.
`timescale 1ns/1ps

module tb_uart_frame_assembler;

    localparam int DBITS = 8;
    localparam int FB    = 18;
    localparam int TO    = 100;
    localparam int FW    = FB * DBITS;
    localparam int CW    = $clog2(FB + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic [FW-1:0]    frame_data;
    logic [DBITS-1:0] frame_cmd;
    logic             frame_valid;
    logic             frame_ready;
    logic             err_mismatch, err_timeout, err_overrun;
    logic [CW-1:0]    byte_count;

    uart_frame_assembler #(
        .DBITS(DBITS), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_data(frame_data), .frame_cmd(frame_cmd), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Cycles each pulse/flag is seen high, sampled on the falling edge.
    int m_cnt = 0, t_cnt = 0, o_cnt = 0, v_cnt = 0;
    always @(negedge clk) begin
        if (err_mismatch) m_cnt++;
        if (err_timeout)  t_cnt++;
        if (err_overrun)  o_cnt++;
        if (frame_valid)  v_cnt++;
    end

    typedef struct {
        logic [7:0]    first;
        logic [7:0]    fill;
        logic [7:0]    last;
        logic          exp_valid;
        logic          exp_mismatch;
        logic [CW-1:0] exp_count;
        logic [7:0]    exp_cmd;
    } vec_t;

    task automatic check(input string name, input logic [FW-1:0] actual, input logic [FW-1:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_at(input int i, input logic [7:0] first, input logic [7:0] fill,
                                           input logic [7:0] last);
        if (i == 0) return first;
        if (i == FB - 1) return last;
        return fill;
    endfunction

    function automatic logic [FW-1:0] build(input logic [7:0] first, input logic [7:0] fill, input logic [7:0] last);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < FB; i++) f[FW-1-8*i -: 8] = byte_at(i, first, fill, last);
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_bytes(input int from, input int to, input logic [7:0] first, input logic [7:0] fill,
                              input logic [7:0] last);
        for (int i = from; i < to; i++) send_byte(byte_at(i, first, fill, last));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[5];
    int m0, t0, o0, v0;
    logic [FW-1:0] held;

    initial begin
        vecs[0] = '{8'h41, 8'h00, 8'h41, 1'b1, 1'b0, CW'(18), 8'h41};
        vecs[1] = '{8'h43, 8'h55, 8'h44, 1'b0, 1'b1, CW'(0),  8'h44};
        vecs[2] = '{8'hFF, 8'hAA, 8'hFF, 1'b1, 1'b0, CW'(18), 8'hFF};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b0, 1'b1, CW'(0),  8'h01};
        vecs[4] = '{8'h42, 8'h12, 8'h42, 1'b1, 1'b0, CW'(18), 8'h42};

        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; frame_ready = 1'b0;
        repeat (3) tick();
        check("reset frame_data", frame_data, '0);
        check("reset frame_valid", FW'(frame_valid), '0);
        check("reset byte_count", FW'(byte_count), '0);
        check("reset errors", FW'({err_mismatch, err_timeout, err_overrun}), '0);
        reset = 1'b0;
        tick();

        // Whole frames with the consumer always ready.
        frame_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m0 = m_cnt; t0 = t_cnt; o0 = o_cnt; v0 = v_cnt;
            send_bytes(0, FB - 1, vecs[k].first, vecs[k].fill, vecs[k].last);
            check($sformatf("v%0d count17", k), FW'(byte_count), FW'(17));
            send_byte(vecs[k].last);
            check($sformatf("v%0d valid", k), FW'(frame_valid), FW'(vecs[k].exp_valid));
            check($sformatf("v%0d mismatch", k), FW'(err_mismatch), FW'(vecs[k].exp_mismatch));
            check($sformatf("v%0d count", k), FW'(byte_count), FW'(vecs[k].exp_count));
            if (vecs[k].exp_valid) begin
                check($sformatf("v%0d cmd", k), FW'(frame_cmd), FW'(vecs[k].exp_cmd));
                check($sformatf("v%0d header", k), FW'(frame_data[FW-1 -: 8]), FW'(vecs[k].first));
                check($sformatf("v%0d data", k), frame_data, build(vecs[k].first, vecs[k].fill, vecs[k].last));
            end
            tick();
            check($sformatf("v%0d valid after", k), FW'(frame_valid), '0);
            check($sformatf("v%0d count after", k), FW'(byte_count), '0);
            check($sformatf("v%0d valid cycles", k), FW'(v_cnt - v0), FW'(vecs[k].exp_valid));
            check($sformatf("v%0d mismatch pulses", k), FW'(m_cnt - m0), FW'(vecs[k].exp_mismatch));
            check($sformatf("v%0d other errs", k), FW'((t_cnt - t0) + (o_cnt - o0)), '0);
        end

        // Timeout: 5 bytes then idle.
        frame_ready = 1'b0;
        m0 = m_cnt; t0 = t_cnt; o0 = o_cnt;
        send_bytes(0, 5, 8'h11, 8'h22, 8'h33);
        check("to count5", FW'(byte_count), FW'(5));
        repeat (TO - 10) tick();
        check("to not yet", FW'(t_cnt - t0), '0);
        check("to count held", FW'(byte_count), FW'(5));
        repeat (20) tick();
        check("to pulses", FW'(t_cnt - t0), FW'(1));
        check("to count cleared", FW'(byte_count), '0);
        check("to other errs", FW'((m_cnt - m0) + (o_cnt - o0)), '0);
        frame_ready = 1'b1;
        v0 = v_cnt;
        send_bytes(0, FB, 8'h42, 8'h07, 8'h42);
        check("to next valid", FW'(frame_valid), FW'(1));
        check("to next cmd", FW'(frame_cmd), FW'(8'h42));
        check("to next data", frame_data, build(8'h42, 8'h07, 8'h42));
        tick();

        // Back-pressure: frame held while three bytes are dropped.
        frame_ready = 1'b0;
        send_bytes(0, FB, 8'h5A, 8'h3C, 8'h5A);
        held = build(8'h5A, 8'h3C, 8'h5A);
        check("bp valid", FW'(frame_valid), FW'(1));
        o0 = o_cnt; m0 = m_cnt; t0 = t_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0 + 8'(i));
            check($sformatf("bp overrun %0d", i), FW'(err_overrun), FW'(1));
            tick();
            check($sformatf("bp overrun low %0d", i), FW'(err_overrun), '0);
        end
        repeat (TO + 5) tick();
        check("bp overrun pulses", FW'(o_cnt - o0), FW'(3));
        check("bp data stable", frame_data, held);
        check("bp still valid", FW'(frame_valid), FW'(1));
        check("bp no other errs", FW'((m_cnt - m0) + (t_cnt - t0)), '0);
        frame_ready = 1'b1;
        #1;
        check("bp valid before edge", FW'(frame_valid), FW'(1));
        tick();
        check("bp valid dropped", FW'(frame_valid), '0);

        // Simultaneous accept and new first byte.
        frame_ready = 1'b0;
        send_bytes(0, FB, 8'h77, 8'h01, 8'h77);
        check("sa held", FW'(frame_valid), FW'(1));
        o0 = o_cnt;
        frame_ready = 1'b1;
        send_byte(8'h66);
        frame_ready = 1'b0;
        check("sa count1", FW'(byte_count), FW'(1));
        check("sa valid low", FW'(frame_valid), '0);
        check("sa no overrun", FW'(o_cnt - o0), '0);
        send_bytes(1, FB, 8'h66, 8'h99, 8'h66);
        check("sa second valid", FW'(frame_valid), FW'(1));
        check("sa second data", frame_data, build(8'h66, 8'h99, 8'h66));
        frame_ready = 1'b1;
        tick();
        check("sa released", FW'(frame_valid), '0);

        // Asynchronous reset in the middle of a frame.
        send_bytes(0, 9, 8'h9C, 8'h5D, 8'h9C);
        check("rst count9", FW'(byte_count), FW'(9));
        m0 = m_cnt; t0 = t_cnt; o0 = o_cnt; v0 = v_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst async data", frame_data, '0);
        check("rst async count", FW'(byte_count), '0);
        check("rst async valid", FW'(frame_valid), '0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst no pulses", FW'((m_cnt - m0) + (t_cnt - t0) + (o_cnt - o0) + (v_cnt - v0)), '0);
        send_bytes(0, FB, 8'h52, 8'h34, 8'h52);
        check("rst next valid", FW'(frame_valid), FW'(1));
        check("rst next data", frame_data, build(8'h52, 8'h34, 8'h52));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
